// File: rtl/sw_operand_entry.sv
// sw_operand_entry: button debounce, operand capture FSM and LED mux drive.
// Optional undo path built when SW_ENTRY_UNDO_EN is defined.
module sw_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WIDTH           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  input  logic             btn_undo,
  input  logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [3:0]       op_code,
  output logic             op_valid,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] data0,
  output logic [WIDTH-1:0] data1,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_SHOW = 2'b11
  } state_t;

  state_t state;

  logic [WIDTH-1:0] sw_s1;
  logic [WIDTH-1:0] sw_sync;
  logic             ent_s1;
  logic             ent_sync;
  logic             ent_stable;
  logic [CW-1:0]    ent_cnt;
  logic             enter_p;

  // two-flop synchronisers for switches and Enter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1    <= '0;
      sw_sync  <= '0;
      ent_s1   <= 1'b0;
      ent_sync <= 1'b0;
    end else begin
      sw_s1    <= sw;
      sw_sync  <= sw_s1;
      ent_s1   <= btn_enter;
      ent_sync <= ent_s1;
    end
  end

  // Enter debounce: accept a new level after CMAX+1 stable cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_cnt    <= '0;
      ent_stable <= 1'b0;
    end else if (ent_sync == ent_stable) begin
      ent_cnt <= '0;
    end else if (ent_cnt == CMAX) begin
      ent_cnt    <= '0;
      ent_stable <= ent_sync;
    end else begin
      ent_cnt <= ent_cnt + 1'b1;
    end
  end

  assign enter_p = ent_sync & ~ent_stable & (ent_cnt == CMAX);

`ifdef SW_ENTRY_UNDO_EN
  logic          und_s1;
  logic          und_sync;
  logic          und_stable;
  logic [CW-1:0] und_cnt;
  logic          undo_p;

  // Undo synchroniser and debounce, same scheme as Enter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      und_s1     <= 1'b0;
      und_sync   <= 1'b0;
      und_cnt    <= '0;
      und_stable <= 1'b0;
    end else begin
      und_s1   <= btn_undo;
      und_sync <= und_s1;
      if (und_sync == und_stable) begin
        und_cnt <= '0;
      end else if (und_cnt == CMAX) begin
        und_cnt    <= '0;
        und_stable <= und_sync;
      end else begin
        und_cnt <= und_cnt + 1'b1;
      end
    end
  end

  assign undo_p = und_sync & ~und_stable & (und_cnt == CMAX);
`else
  logic unused_undo;
  assign unused_undo = btn_undo;
`endif

  // entry sequencer with registered operand and display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_A;
      op_a     <= '0;
      op_b     <= '0;
      op_code  <= '0;
      op_valid <= 1'b0;
      sel      <= 2'b00;
      data0    <= '0;
      data1    <= '0;
    end else begin
      op_valid <= 1'b0;
      if (enter_p) begin
        unique case (state)
          S_A: begin
            op_a  <= sw_sync;
            state <= S_B;
          end
          S_B: begin
            op_b  <= sw_sync;
            state <= S_OP;
          end
          S_OP: begin
            op_code  <= sw_sync[3:0];
            op_valid <= 1'b1;
            state    <= S_SHOW;
          end
          S_SHOW: state <= S_A;
        endcase
      end
`ifdef SW_ENTRY_UNDO_EN
      else if (undo_p) begin
        unique case (state)
          S_A:    state <= S_A;
          S_B:    state <= S_A;
          S_OP:   state <= S_B;
          S_SHOW: state <= S_OP;
        endcase
      end
`endif
      unique case (state)
        S_A, S_B: begin
          sel   <= 2'b00;
          data0 <= sw_sync;
        end
        S_OP: begin
          sel   <= 2'b01;
          data1 <= {{(WIDTH-4){1'b0}}, sw_sync[3:0]};
        end
        S_SHOW: begin
          sel   <= 2'b10;
          data1 <= result;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_sw_operand_entry.sv
// tb_sw_operand_entry: directed stimulus with an op_valid scoreboard.
// Honours SW_ENTRY_UNDO_EN the same way as the design.
module tb_sw_operand_entry;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw;
  logic         btn_enter;
  logic         btn_undo;
  logic [W-1:0] result;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   op_code;
  logic         op_valid;
  logic [1:0]   sel;
  logic [W-1:0] data0;
  logic [W-1:0] data1;
  logic [1:0]   state_dbg;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  c;
  } op_t;

  op_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  nvalid = 0;

  sw_operand_entry #(
    .DEBOUNCE_CYCLES(4),
    .WIDTH(W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .btn_enter(btn_enter),
    .btn_undo(btn_undo),
    .result(result),
    .op_a(op_a),
    .op_b(op_b),
    .op_code(op_code),
    .op_valid(op_valid),
    .sel(sel),
    .data0(data0),
    .data1(data1),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    btn_enter = 1'b1;
    cyc(n);
    btn_enter = 1'b0;
    cyc(12);
  endtask

  task automatic press_undo(input int n);
    btn_undo = 1'b1;
    cyc(n);
    btn_undo = 1'b0;
    cyc(12);
  endtask

  // scoreboard monitor: every op_valid pulse must match a queued entry
  always @(negedge clk) begin
    if (rst_n && op_valid) begin
      op_t e;
      nvalid++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL op_valid_unexpected: got a=%h b=%h c=%h expected none",
                 op_a, op_b, op_code);
      end else begin
        e = exp_q.pop_front();
        if (op_a !== e.a || op_b !== e.b || op_code !== e.c) begin
          fails++;
          $display("FAIL op_valid_fields: got %h %h %h expected %h %h %h",
                   op_a, op_b, op_code, e.a, e.b, e.c);
        end
      end
    end
  end

  initial begin
    sw = '0;
    btn_enter = 1'b0;
    btn_undo = 1'b0;
    result = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    chk("rst_op_a", 32'(op_a), 32'h0);
    chk("rst_op_b", 32'(op_b), 32'h0);
    chk("rst_op_code", 32'(op_code), 32'h0);
    chk("rst_op_valid", 32'(op_valid), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_data0", 32'(data0), 32'h0);
    chk("rst_data1", 32'(data1), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    sw = 16'h1234;
    press(10);
    chk("a_state", 32'(state_dbg), 32'h1);
    chk("a_op_a", 32'(op_a), 32'h1234);
    chk("a_sel", 32'(sel), 32'h0);
    chk("a_data0", 32'(data0), 32'h1234);

    sw = 16'h00FF;
    press(10);
    chk("b_state", 32'(state_dbg), 32'h2);
    chk("b_op_b", 32'(op_b), 32'h00FF);
    chk("b_sel", 32'(sel), 32'h1);
    chk("b_data1", 32'(data1), 32'h000F);

    sw = 16'h0003;
    cyc(3);
    chk("op_data1_echo", 32'(data1), 32'h0003);
    chk("op_code_hold", 32'(op_code), 32'h0);

    result = 16'h1333;
    exp_q.push_back('{a: 16'h1234, b: 16'h00FF, c: 4'h3});
    press(10);
    chk("show_state", 32'(state_dbg), 32'h3);
    chk("show_op_code", 32'(op_code), 32'h3);
    chk("show_sel", 32'(sel), 32'h2);
    chk("show_data1", 32'(data1), 32'h1333);
    chk("show_data0_hold", 32'(data0), 32'h00FF);
    result = 16'hABCD;
    cyc(2);
    chk("show_data1_track", 32'(data1), 32'hABCD);

    press_undo(10);
`ifdef SW_ENTRY_UNDO_EN
    chk("undo1_state", 32'(state_dbg), 32'h2);
`else
    chk("undo1_state", 32'(state_dbg), 32'h3);
`endif
    press_undo(10);
`ifdef SW_ENTRY_UNDO_EN
    chk("undo2_state", 32'(state_dbg), 32'h1);
`else
    chk("undo2_state", 32'(state_dbg), 32'h3);
`endif
    chk("undo_op_a", 32'(op_a), 32'h1234);
    chk("undo_op_b", 32'(op_b), 32'h00FF);
    chk("undo_op_code", 32'(op_code), 32'h3);

    sw = 16'hFFFF;
    rst_n = 1'b0;
    #1;
    chk("mrst_op_a", 32'(op_a), 32'h0);
    chk("mrst_op_b", 32'(op_b), 32'h0);
    chk("mrst_op_code", 32'(op_code), 32'h0);
    chk("mrst_sel", 32'(sel), 32'h0);
    chk("mrst_data0", 32'(data0), 32'h0);
    chk("mrst_data1", 32'(data1), 32'h0);
    chk("mrst_state", 32'(state_dbg), 32'h0);
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    chk("mrst_after_state", 32'(state_dbg), 32'h0);

    sw = 16'h2222;
    btn_enter = 1'b1;
    cyc(3);
    btn_enter = 1'b0;
    cyc(12);
    chk("glitch_state", 32'(state_dbg), 32'h0);
    chk("glitch_op_a", 32'(op_a), 32'h0);
    press(10);
    chk("bounce_state", 32'(state_dbg), 32'h1);
    chk("bounce_op_a", 32'(op_a), 32'h2222);

    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    sw = 16'h5A5A;
    btn_enter = 1'b1;
    cyc(20);
    sw = 16'h0F0F;
    cyc(80);
    chk("held_state", 32'(state_dbg), 32'h1);
    chk("held_op_a", 32'(op_a), 32'h5A5A);
    btn_enter = 1'b0;
    cyc(12);
    chk("held_rel_state", 32'(state_dbg), 32'h1);
    chk("held_rel_op_a", 32'(op_a), 32'h5A5A);

    btn_enter = 1'b1;
    btn_undo = 1'b1;
    cyc(10);
    btn_enter = 1'b0;
    btn_undo = 1'b0;
    cyc(12);
    chk("simul_state", 32'(state_dbg), 32'h2);
    chk("simul_op_b", 32'(op_b), 32'h0F0F);

    sw = 16'h0007;
    exp_q.push_back('{a: 16'h5A5A, b: 16'h0F0F, c: 4'h7});
    press(10);
    chk("fin_state", 32'(state_dbg), 32'h3);
    chk("fin_op_code", 32'(op_code), 32'h7);
    cyc(5);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    chk("valid_count", 32'(nvalid), 32'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
